ifetch_sa_cache: RTL and testbench

- Parametrised successor of the instruction-fetch stage. Provides an N-way set-associative instruction cache with multi-word lines, per-set round-robin replacement and sequential line refill over a single-word memory handshake.
- Supports abort on jump or full invalidation, with a safe drain of any in-flight memory transaction.
- Sits between pc_reg and if_id. Requests words from the memory controller.

---
 rtl/ifetch_sa_cache_if.sv | 35 +++
 rtl/ifetch_sa_cache.sv | 176 +++++++++++++++++
 tb/tb_ifetch_sa_cache.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_sa_cache_if.sv
// ifetch_sa_cache_if: fetch-side and memory-side signals of the instruction cache.
//   pc_valid/pc_i    fetch request; pc_i is held while stall=1
//   jump/inv_all     branch redirect kill / whole-cache invalidate
//   pc_o/inst_o      delivered pc and instruction, qualified by inst_valid
//   stall            request cannot be accepted or completed this cycle
//   mem_req/mem_addr single-word read request toward the memory controller
//   mem_data         read data, qualified by the one-cycle pulse mem_valid
// master = fetch pipeline plus memory (drives requests and read data);
// slave  = the cache.
interface ifetch_sa_cache_if #(
    parameter int ADDR_W = 32
);
    logic              pc_valid;
    logic [ADDR_W-1:0] pc_i;
    logic              jump;
    logic              inv_all;
    logic [ADDR_W-1:0] pc_o;
    logic [31:0]       inst_o;
    logic              inst_valid;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_valid;

    modport master (
        output pc_valid, pc_i, jump, inv_all, mem_data, mem_valid,
        input  pc_o, inst_o, inst_valid, stall, mem_req, mem_addr
    );

    modport slave (
        input  pc_valid, pc_i, jump, inv_all, mem_data, mem_valid,
        output pc_o, inst_o, inst_valid, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/ifetch_sa_cache.sv
// ifetch_sa_cache: N-way set-associative instruction cache for the fetch stage.
// Hits deliver the instruction one cycle after the lookup. A miss refills the
// whole line word 0 upward through a single-word memory handshake, then the held
// pc hits. jump/inv_all abort a refill; a request already on the bus is drained.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   rdy    global enable; low freezes every register and forces stall low
//   bus    ifetch_sa_cache_if.slave (fetch request/response and memory port)
module ifetch_sa_cache #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rdy,
    ifetch_sa_cache_if.slave   bus
);
    localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W  = 2 + $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, DRAIN} state_t;

    state_t            state;
    logic [WSEL_W-1:0] k;
    logic [LINE_W-1:0] base_line;   // tag+index of the line being refilled
    logic [WAY_W-1:0]  victim_r;

    logic [WAYS-1:0]   valid    [SETS];
    logic [WAY_W-1:0]  rr       [SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [31:0]       data_mem [WAYS][SETS][LINE_WORDS];

    // Lookup fields of the incoming pc.
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic              unused_pc_bits;

    assign idx            = bus.pc_i[OFF_W +: IDX_W];
    assign tag            = bus.pc_i[ADDR_W-1 -: TAG_W];
    assign wsel           = (LINE_WORDS > 1) ? bus.pc_i[2 +: WSEL_W] : '0;
    assign unused_pc_bits = ^bus.pc_i[1:0];

    // Fields of the line under refill.
    logic [IDX_W-1:0]  line_idx;
    logic [TAG_W-1:0]  line_tag;

    assign line_idx = base_line[IDX_W-1:0];
    assign line_tag = base_line[LINE_W-1:IDX_W];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;

    // NOTE: every always_comb output gets a default before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tag_mem[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
        victim = rr[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[idx][w]) victim = WAY_W'(w);
        end
    end

    logic go, lookup_hit, lookup_miss, abort, last_word, fill_wr;

    assign go          = bus.pc_valid && !bus.jump && !bus.inv_all;
    assign lookup_hit  = (state == IDLE) && go && hit;
    assign lookup_miss = (state == IDLE) && go && !hit;
    assign abort       = bus.jump || bus.inv_all;
    assign last_word   = (k == WSEL_W'(LINE_WORDS - 1));
    // An abort arriving with the data beat discards the beat.
    assign fill_wr     = rdy && (state == REFILL) && bus.mem_valid && !abort;

    assign bus.stall = rdy && ((state != IDLE) || lookup_miss);

    // NOTE: sequential state is assigned with <= only, so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            k              <= '0;
            base_line      <= '0;
            victim_r       <= '0;
            bus.inst_valid <= 1'b0;
            bus.pc_o       <= '0;
            bus.inst_o     <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                rr[s]    <= '0;
            end
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    bus.inst_valid <= lookup_hit;
                    if (lookup_hit) begin
                        bus.pc_o   <= bus.pc_i;
                        bus.inst_o <= data_mem[hit_way][idx][wsel];
                    end
                    if (lookup_miss) begin
                        // The victim is invalid for the whole refill so an abort
                        // can never leave a half-written line marked valid.
                        valid[idx][victim] <= 1'b0;
                        victim_r     <= victim;
                        base_line    <= bus.pc_i[ADDR_W-1:OFF_W];
                        k            <= '0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {bus.pc_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                        state        <= REFILL;
                    end
                end
                REFILL: begin
                    bus.inst_valid <= 1'b0;
                    if (abort) begin
                        // A request still waiting on the bus must be drained.
                        if (bus.mem_req && !bus.mem_valid) begin
                            state <= DRAIN;
                        end else begin
                            bus.mem_req <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (bus.mem_valid) begin
                        bus.mem_req <= 1'b0;
                        k           <= k + WSEL_W'(1);
                        if (last_word) begin
                            valid[line_idx][victim_r] <= 1'b1;
                            if (victim_r == rr[line_idx]) begin
                                rr[line_idx] <= (rr[line_idx] == WAY_W'(WAYS - 1)) ?
                                                '0 : rr[line_idx] + WAY_W'(1);
                            end
                            state <= IDLE;
                        end
                    end else if (!bus.mem_req) begin
                        // One idle cycle after each beat, then the next word.
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {base_line, OFF_W'(0)} | ADDR_W'({k, 2'b00});
                    end
                end
                DRAIN: begin
                    bus.inst_valid <= 1'b0;
                    if (bus.mem_valid) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (bus.inv_all) begin
                for (int s = 0; s < SETS; s++) valid[s] <= '0;
            end
        end
    end

    // NOTE: line storage is not reset; the valid bits alone decide whether its contents mean anything.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            data_mem[victim_r][line_idx][k] <= bus.mem_data;
            if (last_word) tag_mem[victim_r][line_idx] <= line_tag;
        end
    end
endmodule

// File: tb/tb_ifetch_sa_cache.sv
// tb_ifetch_sa_cache: self-checking bench for ifetch_sa_cache.
// The bench plays both the fetch pipeline and the memory controller. A
// behavioural model (per-set valid/tag arrays plus round-robin pointers)
// predicts hit or miss, the victim way and the refill address sequence; memory
// contents are a fixed function of the address.
module tb_ifetch_sa_cache;
    localparam int ADDR_W = 32;
    localparam int SETS   = 64;
    localparam int WAYS   = 2;
    localparam int LW     = 4;
    localparam int OFF_W  = 2 + $clog2(LW);
    localparam int IDX_W  = $clog2(SETS);

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;

    always #5 clk = ~clk;

    ifetch_sa_cache_if #(.ADDR_W(ADDR_W)) bus ();

    ifetch_sa_cache #(
        .ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    // Reference model state.
    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int          m_rr    [SETS];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> OFF_W) % SETS);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (OFF_W + IDX_W);
    endfunction

    function automatic int model_hit_way(input logic [31:0] pc);
        int s;
        s = set_of(pc);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
        return -1;
    endfunction

    function automatic int model_victim(input logic [31:0] pc);
        int s;
        s = set_of(pc);
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w]) return w;
        return m_rr[s];
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] pc);
        return {pc[31:OFF_W], {OFF_W{1'b0}}};
    endfunction

    task automatic model_clear_all();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endtask

    // Wait (bounded) for mem_req; the request must appear one cycle after
    // the miss edge or after the previous beat.
    task automatic wait_req();
        int n;
        n = 0;
        while (!bus.mem_req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.mem_req) begin
            check("mem_req_timeout", 32'(bus.mem_req), 32'd1);
            finish_run();
        end
        check("req_latency", n, 1);
    endtask

    // Serve one word of a refill with a random response delay and an
    // optional rdy freeze of `freeze` cycles before the data beat.
    task automatic serve_word(input logic [31:0] addr, input int freeze);
        int d;
        wait_req();
        check("mem_addr", bus.mem_addr, addr);
        check("stall_refill", 32'(bus.stall), 32'd1);
        d = $urandom_range(0, 2);
        repeat (d) begin
            @(posedge clk); #1;
            check("mem_req_hold", 32'(bus.mem_req), 32'd1);
            check("mem_addr_hold", bus.mem_addr, addr);
        end
        if (freeze > 0) begin
            rdy = 1'b0;
            #1;
            check("stall_frozen", 32'(bus.stall), 32'd0);
            repeat (freeze) begin
                @(posedge clk); #1;
                check("frz_req", 32'(bus.mem_req), 32'd1);
                check("frz_addr", bus.mem_addr, addr);
                check("frz_iv", 32'(bus.inst_valid), 32'd0);
            end
            rdy = 1'b1;
        end
        bus.mem_valid = 1'b1;
        bus.mem_data  = mem_word(addr);
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        check("mem_req_gap", 32'(bus.mem_req), 32'd0);
    endtask

    // Complete fetch of one pc: hit, or miss + full refill + delivery.
    task automatic fetch(input logic [31:0] pc, input int freeze_word);
        int s, hw, v;
        logic [31:0] base;
        s    = set_of(pc);
        hw   = model_hit_way(pc);
        base = line_base(pc);
        bus.pc_valid = 1'b1;
        bus.pc_i     = pc;
        #1;
        check("stall_lookup", 32'(bus.stall), 32'(hw < 0));
        if (hw < 0) begin
            v = model_victim(pc);
            for (int k = 0; k < LW; k++)
                serve_word(base + 32'(4 * k), (k == freeze_word) ? 3 : 0);
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = tag_of(pc);
            if (v == m_rr[s]) m_rr[s] = (m_rr[s] + 1) % WAYS;
            #1;
            check("stall_after_fill", 32'(bus.stall), 32'd0);
        end else begin
            check("no_req_on_hit", 32'(bus.mem_req), 32'd0);
        end
        @(posedge clk); #1;
        bus.pc_valid = 1'b0;
        check("inst_valid", 32'(bus.inst_valid), 32'd1);
        check("pc_o", bus.pc_o, pc);
        check("inst_o", bus.inst_o, mem_word(pc));
    endtask

    // Miss on pc, serve words below at_word, then abort (jump or inv_all)
    // either while word at_word is pending (drain) or together with its beat.
    task automatic abort_fetch(input logic [31:0] pc, input int at_word,
                               input bit use_inv, input bit with_data);
        int s, v;
        logic [31:0] base, addr;
        s    = set_of(pc);
        base = line_base(pc);
        addr = base + 32'(4 * at_word);
        v    = model_victim(pc);
        m_valid[s][v] = 1'b0;
        bus.pc_valid = 1'b1;
        bus.pc_i     = pc;
        #1;
        check("stall_miss", 32'(bus.stall), 32'd1);
        for (int k = 0; k < at_word; k++) serve_word(base + 32'(4 * k), 0);
        wait_req();
        check("mem_addr_abort", bus.mem_addr, addr);
        bus.pc_valid = 1'b0;
        if (use_inv) bus.inv_all = 1'b1;
        else         bus.jump    = 1'b1;
        if (with_data) begin
            bus.mem_valid = 1'b1;
            bus.mem_data  = mem_word(addr);
        end
        @(posedge clk); #1;
        bus.jump    = 1'b0;
        bus.inv_all = 1'b0;
        if (use_inv) model_clear_all();
        if (!with_data) begin
            check("drain_req", 32'(bus.mem_req), 32'd1);
            check("drain_addr", bus.mem_addr, addr);
            #1;
            check("drain_stall", 32'(bus.stall), 32'd1);
            @(posedge clk); #1;
            bus.jump = 1'b1;
            @(posedge clk); #1;
            bus.jump = 1'b0;
            check("drain_req2", 32'(bus.mem_req), 32'd1);
            check("drain_addr2", bus.mem_addr, addr);
            bus.mem_valid = 1'b1;
            bus.mem_data  = mem_word(addr);
            @(posedge clk); #1;
        end
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        check("abort_req", 32'(bus.mem_req), 32'd0);
        check("abort_iv", 32'(bus.inst_valid), 32'd0);
        #1;
        check("abort_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        check("idle_no_req", 32'(bus.mem_req), 32'd0);
    endtask

    task automatic inv_pulse();
        bus.pc_valid = 1'b0;
        bus.inv_all  = 1'b1;
        #1;
        check("inv_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.inv_all = 1'b0;
        model_clear_all();
    endtask

    task automatic jump_idle(input logic [31:0] pc);
        bus.pc_valid = 1'b1;
        bus.pc_i     = pc;
        bus.jump     = 1'b1;
        #1;
        check("jump_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.jump     = 1'b0;
        bus.pc_valid = 1'b0;
        check("jump_iv", 32'(bus.inst_valid), 32'd0);
        check("jump_req", 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        #2_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        finish_run();
    end

    initial begin
        logic [31:0] pc;
        int          r;
        rst_n         = 1'b0;
        rdy           = 1'b0;
        bus.pc_valid  = 1'b0;
        bus.pc_i      = '0;
        bus.jump      = 1'b0;
        bus.inv_all   = 1'b0;
        bus.mem_data  = '0;
        bus.mem_valid = 1'b0;
        model_clear_all();
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_pc_o", bus.pc_o, 32'd0);
        check("rst_inst_o", bus.inst_o, 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        rst_n = 1'b1;
        rdy   = 1'b1;
        @(posedge clk); #1;

        // Cold miss and refill of line 0, then a hit in the same line.
        fetch(32'h0, -1);
        fetch(32'h4, -1);

        // Conflicts in set 0: round-robin eviction.
        fetch(32'h1000, -1);
        fetch(32'h2000, -1);
        fetch(32'h1000, -1);
        fetch(32'h0000, -1);
        fetch(32'h2004, -1);
        fetch(32'h1004, -1);

        jump_idle(32'h2000);

        // jump while word 1 of line 0x40 is pending, then a full refetch.
        abort_fetch(32'h40, 1, 1'b0, 1'b0);
        fetch(32'h40, -1);

        // rdy freeze in the middle of a refill.
        fetch(32'h80, 1);

        // inv_all wipes cached line 0.
        inv_pulse();
        fetch(32'h4, -1);

        // jump together with the final data beat: no drain, line stays invalid.
        abort_fetch(32'hC0, LW - 1, 1'b0, 1'b1);
        fetch(32'hC0, -1);

        // inv_all during a refill.
        abort_fetch(32'h100, 2, 1'b1, 1'b0);
        fetch(32'h100, -1);

        // Randomized traffic over 4 sets x 4 tags (2 ways) to force evictions.
        for (int i = 0; i < 300; i++) begin
            pc = (32'($urandom_range(0, 3)) << 10) |
                 (32'($urandom_range(0, 3)) << 4)  |
                 (32'($urandom_range(0, 3)) << 2);
            r = int'($urandom_range(0, 99));
            if (r < 8 && model_hit_way(pc) < 0)
                abort_fetch(pc, int'($urandom_range(0, LW - 1)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (r >= 8 && r < 11)
                inv_pulse();
            else if (r >= 11 && r < 15 && model_hit_way(pc) >= 0)
                jump_idle(pc);
            else
                fetch(pc, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1);
        end

        finish_run();
    end
endmodule
